// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the pipeline register bundles
// used by the command master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } ap_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } dp_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane helper: replicates write data across lanes, or
// right-justifies and masks read data by size and address.
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic        rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = data_i >> {addr_i, 3'b000};
    data_o  = data_i;
    if (rd_i) begin
      unique case (size_i)
        HSIZE_BYTE: data_o = {24'b0, shifted[7:0]};
        HSIZE_HALF: data_o = {16'b0, shifted[15:0]};
        HSIZE_WORD: data_o = shifted;
        default:    data_o = shifted;
      endcase
    end else begin
      unique case (size_i)
        HSIZE_BYTE: data_o = {4{data_i[7:0]}};
        HSIZE_HALF: data_o = {2{data_i[15:0]}};
        HSIZE_WORD: data_o = data_i;
        default:    data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: command stream in, pipelined
// address/data phases out, one response per command in order.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_write_o,
  output logic                  rsp_err_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  idle_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hsize_o,
  output logic                  hwrite_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [31:0]           hwdata_o,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  input  logic [31:0]           hrdata_i
);

  ap_t                   ap_q, ap_d;
  dp_t                   dp_q, dp_d;
  rsp_t                  rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  accept;
  logic [31:0]           wdata_rep;
  logic [31:0]           rdata_al;

  ahb_lane_align u_wr_align (
    .rd_i   (1'b0),
    .size_i (cmd_size_i),
    .addr_i (cmd_addr_i[1:0]),
    .data_i (cmd_wdata_i),
    .data_o (wdata_rep)
  );

  ahb_lane_align u_rd_align (
    .rd_i   (1'b1),
    .size_i (dp_q.size),
    .addr_i (dp_q.addr),
    .data_i (hrdata_i),
    .data_o (rdata_al)
  );

  // An empty AP may fill even during a wait state: the new
  // address phase simply stretches until hready_i returns.
  assign cmd_ready_o = ~hreset & (~ap_q.valid | hready_i);
  assign accept      = cmd_valid_i & cmd_ready_o;

  always_comb begin
    ap_d    = ap_q;
    dp_d    = dp_q;
    haddr_d = haddr_q;
    rsp_d   = '0;
    if (hready_i) begin
      dp_d.valid = ap_q.valid;
      dp_d.write = ap_q.write;
      dp_d.size  = ap_q.size;
      dp_d.addr  = haddr_q[1:0];
      dp_d.wdata = ap_q.wdata;
      if (dp_q.valid) begin
        rsp_d.valid = 1'b1;
        rsp_d.write = dp_q.write;
        rsp_d.err   = (hresp_i == HRESP_ERROR);
        rsp_d.rdata = dp_q.write ? 32'b0 : rdata_al;
      end
    end
    if (hready_i | ~ap_q.valid) begin
      ap_d.valid = accept;
      if (accept) begin
        ap_d.write = cmd_write_i;
        ap_d.size  = cmd_size_i;
        ap_d.wdata = wdata_rep;
        haddr_d    = cmd_addr_i;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ap_q    <= '0;
      dp_q    <= '0;
      rsp_q   <= '0;
      haddr_q <= '0;
    end else begin
      ap_q    <= ap_d;
      dp_q    <= dp_d;
      rsp_q   <= rsp_d;
      haddr_q <= haddr_d;
    end
  end

  assign htrans_o    = ap_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize_o     = ap_q.size;
  assign hwrite_o    = ap_q.write;
  assign haddr_o     = haddr_q;
  assign hwdata_o    = (dp_q.valid & dp_q.write) ? dp_q.wdata : 32'b0;
  assign idle_o      = ~hreset & ~ap_q.valid & ~dp_q.valid;
  assign rsp_valid_o = rsp_q.valid;
  assign rsp_write_o = rsp_q.write;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_rdata_o = rsp_q.rdata;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master with a byte-memory AHB slave
// model that supports programmable wait states and error replies.
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [2:0]  cmd_size_i;
  logic [15:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o, rsp_write_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        idle_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o;
  logic        hwrite_o;
  logic [15:0] haddr_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;

  ahb_cmd_master #(.ADDR_WIDTH(16)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_size_i(cmd_size_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .idle_o(idle_o), .htrans_o(htrans_o), .hsize_o(hsize_o),
    .hwrite_o(hwrite_o), .haddr_o(haddr_o), .hwdata_o(hwdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 hclk = ~hclk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model
  logic [7:0]  mem [0:255];
  int          wait_n = 0;
  logic        err_en = 1'b0;
  logic [15:0] err_addr = 16'h0060;
  logic        s_v, s_w, s_e;
  logic [2:0]  s_sz;
  logic [15:0] s_a;
  int          s_cnt;

  always_comb begin
    logic [7:0] b;
    b        = {s_a[7:2], 2'b00};
    hready_i = 1'b1;
    hresp_i  = HRESP_OKAY;
    hrdata_i = '0;
    if (s_v) begin
      hready_i = (s_cnt == 0);
      if (s_e) hresp_i = HRESP_ERROR;
      if (!s_w)
        hrdata_i = {mem[b + 8'd3], mem[b + 8'd2],
                    mem[b + 8'd1], mem[b]};
    end
  end

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      s_v   <= 1'b0;
      s_e   <= 1'b0;
      s_cnt <= 0;
    end else if (hready_i) begin
      if (s_v && s_w && !s_e) begin
        for (int i = 0; i < 4; i++) begin
          int off, nb;
          off = int'(s_a[1:0]);
          nb  = (s_sz == 3'd0) ? 1 : (s_sz == 3'd1) ? 2 : 4;
          if (i >= off && i < off + nb)
            mem[{s_a[7:2], 2'b00} + 8'(i)] <= hwdata_o[8*i +: 8];
        end
      end
      s_v   <= (htrans_o == HTRANS_NONSEQ);
      s_w   <= hwrite_o;
      s_sz  <= hsize_o;
      s_a   <= haddr_o;
      s_e   <= err_en && (haddr_o == err_addr);
      s_cnt <= (err_en && haddr_o == err_addr) ? 1 : wait_n;
    end else begin
      s_cnt <= s_cnt - 1;
    end
  end

  // Response collector: {err, write, rdata}
  logic [33:0] rq[$];
  always @(negedge hclk)
    if (rsp_valid_o) rq.push_back({rsp_err_o, rsp_write_o, rsp_rdata_o});

  task automatic issue(input logic w, input logic [2:0] sz,
                       input logic [15:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge hclk);
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_size_i  = sz;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    #1;
    while (!cmd_ready_o && n < 50) begin
      @(negedge hclk);
      #1;
      n++;
    end
    if (!cmd_ready_o) chk("accept_timeout", 32'(cmd_ready_o), 1);
    @(posedge hclk);
  endtask

  task automatic cmd_idle();
    @(negedge hclk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int k;
    k = 0;
    while (rq.size() < n && k < 60) begin
      @(negedge hclk);
      k++;
    end
    chk(tag, 32'(rq.size()), 32'(n));
  endtask

  task automatic chk_rsp(input string tag, input int idx, input logic err,
                         input logic w, input logic [31:0] d);
    logic [33:0] e;
    e = (idx < rq.size()) ? rq[idx] : 34'h3_FFFF_FFFF;
    chk({tag, "_err"}, 32'(e[33]), 32'(err));
    chk({tag, "_wr"}, 32'(e[32]), 32'(w));
    chk({tag, "_data"}, e[31:0], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]} = 32'h11223344;
    {mem[8'h4B], mem[8'h4A], mem[8'h49], mem[8'h48]} = 32'h55667788;
    {mem[8'h4F], mem[8'h4E], mem[8'h4D], mem[8'h4C]} = 32'h99AABBCC;
    hreset      = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_size_i  = '0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;

    // Reset state
    repeat (3) @(negedge hclk);
    chk("rst_htrans", 32'(htrans_o), 32'(HTRANS_IDLE));
    chk("rst_ready", 32'(cmd_ready_o), 0);
    chk("rst_idle", 32'(idle_o), 0);
    chk("rst_rsp", 32'(rsp_valid_o), 0);
    chk("rst_hwdata", hwdata_o, 0);
    hreset = 1'b0;
    #1;
    chk("rel_ready", 32'(cmd_ready_o), 1);
    chk("rel_idle", 32'(idle_o), 1);

    // Word write then read, one wait state
    wait_n = 1;
    issue(1'b1, HSIZE_WORD, 16'h0040, 32'hDEADBEEF);
    issue(1'b0, HSIZE_WORD, 16'h0040, 32'h0);
    cmd_idle();
    wait_rsp("wr_rd_count", 2);
    chk_rsp("wr_rd_r0", 0, 1'b0, 1'b1, 32'h0);
    chk_rsp("wr_rd_r1", 1, 1'b0, 1'b0, 32'hDEADBEEF);
    rq.delete();

    // Byte write, lane replication, aligned reads
    issue(1'b1, HSIZE_BYTE, 16'h0041, 32'h0000005A);
    cmd_idle();
    chk("bw_htrans", 32'(htrans_o), 32'(HTRANS_NONSEQ));
    chk("bw_hsize", 32'(hsize_o), 0);
    chk("bw_haddr", 32'(haddr_o), 32'h41);
    @(negedge hclk);
    chk("bw_hwdata", hwdata_o, 32'h5A5A5A5A);
    wait_rsp("bw_count", 1);
    rq.delete();
    issue(1'b0, HSIZE_WORD, 16'h0040, 32'h0);
    issue(1'b0, HSIZE_BYTE, 16'h0043, 32'h0);
    issue(1'b0, HSIZE_HALF, 16'h0042, 32'h0);
    cmd_idle();
    wait_rsp("rd3_count", 3);
    chk_rsp("rd_word", 0, 1'b0, 1'b0, 32'hDEAD5AEF);
    chk_rsp("rd_byte", 1, 1'b0, 1'b0, 32'h000000DE);
    chk_rsp("rd_half", 2, 1'b0, 1'b0, 32'h0000DEAD);
    rq.delete();

    // Four back-to-back reads with valid held high
    repeat (2) @(negedge hclk);
    fork
      begin
        issue(1'b0, HSIZE_WORD, 16'h0040, 32'h0);
        issue(1'b0, HSIZE_WORD, 16'h0044, 32'h0);
        issue(1'b0, HSIZE_WORD, 16'h0048, 32'h0);
        issue(1'b0, HSIZE_WORD, 16'h004C, 32'h0);
        cmd_idle();
      end
      begin
        logic        ph;
        logic [15:0] pa;
        int          ns, gaps;
        bit          seen, ended;
        ph = 1'b1; pa = haddr_o; ns = 0; gaps = 0;
        seen = 0; ended = 0;
        repeat (14) begin
          @(negedge hclk);
          if (!ph) chk("tp_haddr_hold", 32'(haddr_o), 32'(pa));
          if (htrans_o == HTRANS_NONSEQ) begin
            ns++;
            if (ended) gaps++;
            seen = 1;
          end else if (seen) begin
            ended = 1;
          end
          ph = hready_i;
          pa = haddr_o;
        end
        chk("tp_nonseq_cycles", 32'(ns), 7);
        chk("tp_nonseq_gaps", 32'(gaps), 0);
      end
    join
    wait_rsp("tp_count", 4);
    chk_rsp("tp_r0", 0, 1'b0, 1'b0, 32'hDEAD5AEF);
    chk_rsp("tp_r1", 1, 1'b0, 1'b0, 32'h11223344);
    chk_rsp("tp_r2", 2, 1'b0, 1'b0, 32'h55667788);
    chk_rsp("tp_r3", 3, 1'b0, 1'b0, 32'h99AABBCC);
    chk("tp_idle", 32'(idle_o), 1);
    rq.delete();

    // Three wait states in a write data phase with AP occupied
    wait_n = 3;
    issue(1'b1, HSIZE_WORD, 16'h0050, 32'h0BADF00D);
    issue(1'b0, HSIZE_WORD, 16'h0050, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 0) cmd_idle();
      else @(negedge hclk);
      chk("st_hready", 32'(hready_i), 0);
      chk("st_hwdata", hwdata_o, 32'h0BADF00D);
      chk("st_haddr", 32'(haddr_o), 32'h50);
      chk("st_ready", 32'(cmd_ready_o), 0);
      chk("st_rsp", 32'(rq.size()), 0);
    end
    wait_rsp("st_count", 2);
    repeat (5) @(negedge hclk);
    chk("st_exact", 32'(rq.size()), 2);
    chk_rsp("st_r0", 0, 1'b0, 1'b1, 32'h0);
    chk_rsp("st_r1", 1, 1'b0, 1'b0, 32'h0BADF00D);
    rq.delete();

    // Two-cycle ERROR on a read, next command unaffected
    wait_n = 0;
    err_en = 1'b1;
    issue(1'b0, HSIZE_WORD, 16'h0060, 32'h0);
    issue(1'b0, HSIZE_WORD, 16'h0044, 32'h0);
    cmd_idle();
    chk("er_first_resp", 32'(hresp_i), 32'(HRESP_ERROR));
    chk("er_first_ready", 32'(hready_i), 0);
    wait_rsp("er_count", 2);
    chk("er_r0_err", 32'(rq.size() > 0 ? rq[0][33] : 1'b0), 1);
    chk_rsp("er_r1", 1, 1'b0, 1'b0, 32'h11223344);
    err_en = 1'b0;
    rq.delete();

    // Reset with both AP and DP occupied
    wait_n = 3;
    issue(1'b1, HSIZE_WORD, 16'h0070, 32'h12345678);
    issue(1'b0, HSIZE_WORD, 16'h0074, 32'h0);
    cmd_idle();
    chk("mr_busy", 32'(idle_o), 0);
    hreset = 1'b1;
    #1;
    chk("mr_htrans", 32'(htrans_o), 32'(HTRANS_IDLE));
    chk("mr_rsp", 32'(rsp_valid_o), 0);
    chk("mr_hwdata", hwdata_o, 0);
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    #1;
    chk("mr_rel_idle", 32'(idle_o), 1);
    chk("mr_rel_htrans", 32'(htrans_o), 32'(HTRANS_IDLE));
    chk("mr_rel_ready", 32'(cmd_ready_o), 1);
    repeat (8) @(negedge hclk);
    chk("mr_no_stale", 32'(rq.size()), 0);
    chk("mr_mem", 32'(mem[8'h70]), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
